// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider.
// Produces one quotient bit per clock. A start is accepted only in IDLE.
// Results stay in output registers until the next result is loaded or
// until reset.
module seq_restoring_divider #(
  parameter int             N        = 4,
  parameter logic [N-1:0]   DBZ_QUOT = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic         valid,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  // The partial remainder A is always smaller than D after every step, so its
  // top bit is always zero. Only the N low bits are stored. The trial
  // subtraction below is done at N+1 bits, and its sign bit shows the borrow.
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_d;
  logic [N-1:0]   r_dvd;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_rem;
  logic           r_dbz;

  logic [N:0]     w_shift;
  logic [N:0]     w_t;
  logic           w_qbit;
  logic [N-1:0]   w_a_nxt;
  logic [N-1:0]   w_q_nxt;

  // One restoring step: shift {A,Q} left, then do a trial subtraction of D.
  always_comb begin
    w_shift = {r_a, r_q[N-1]};
    w_t     = w_shift - {1'b0, r_d};
    w_qbit  = ~w_t[N];
    w_a_nxt = w_qbit ? w_t[N-1:0] : w_shift[N-1:0];
    w_q_nxt = {r_q[N-2:0], w_qbit};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. A zero divisor skips RUN and goes straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
      S_RUN:  if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: capture the operands on an accepted start, iterate in RUN,
  // and load the output registers on the edge that enters DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_dvd  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_q   <= dividend;
          r_d   <= divisor;
          r_dvd <= dividend;
          r_a   <= '0;
          r_cnt <= '0;
          if (divisor == '0) begin
            r_quot <= DBZ_QUOT;
            r_rem  <= dividend;
            r_dbz  <= 1'b1;
          end
        end
        S_RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_quot <= w_q_nxt;
            r_rem  <= w_a_nxt;
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready       = (r_state == S_IDLE);
  assign valid       = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

  // At valid, check the division identity q*d + r == dividend and r < d.
  always_ff @(posedge clk) begin
    if (!rst && valid && !r_dbz) begin
      assert (({{N{1'b0}}, r_quot} * {{N{1'b0}}, r_d} + {{N{1'b0}}, r_rem})
              == {{N{1'b0}}, r_dvd});
      assert (r_rem < r_d);
    end
  end

endmodule
